// File: rtl/frame_start_tx.sv
// frame_start_tx: transmit-side frame sequencer.
// Each frame is a fixed pattern read from an external combinational ROM,
// followed by a fixed-length payload taken from a valid/ready source. Words
// leave through one registered valid/ready stream that carries SOF/EOF markers.
module frame_start_tx #(
  parameter int PAT_LEN     = 64,
  parameter int PAYLOAD_LEN = 256,
  parameter int DATA_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic [5:0]        o_rom_index,
  input  logic [DATA_W-1:0] i_rom_data,
  input  logic [DATA_W-1:0] i_pl_data,
  input  logic              i_pl_valid,
  output logic              o_pl_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_sof,
  output logic              o_eof,
  output logic              o_done
);

  localparam int              PL_W     = $clog2(PAYLOAD_LEN + 1);
  localparam logic [6:0]      PAT_LAST = 7'(PAT_LEN - 1);
  localparam logic [PL_W-1:0] PL_LAST  = PL_W'(PAYLOAD_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PATTERN,
    S_PAYLOAD,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        pat_cnt_q, pat_cnt_d;
  logic [PL_W-1:0]   pl_cnt_q, pl_cnt_d;
  // ROM address is kept separately so it can hold its last value once the
  // pattern counter has moved past the final index.
  logic [5:0]        rom_idx_q, rom_idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              done_q, done_d;
  logic              pl_ready;
  logic              slot_free;

  // The output register can take a new word when it is empty or being drained.
  assign slot_free = !valid_q || i_ready;

  assign o_busy      = (state_q != S_IDLE);
  assign o_rom_index = rom_idx_q;
  assign o_pl_ready  = pl_ready;
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_sof       = sof_q;
  assign o_eof       = eof_q;
  assign o_done      = done_q;

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      pat_cnt_q <= '0;
      pl_cnt_q  <= '0;
      rom_idx_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_cnt_q <= pat_cnt_d;
      pl_cnt_q  <= pl_cnt_d;
      rom_idx_q <= rom_idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: pattern words, then payload words, then wait for the
  // final word to be taken before pulsing done.
  always_comb begin
    state_d   = state_q;
    pat_cnt_d = pat_cnt_q;
    pl_cnt_d  = pl_cnt_q;
    rom_idx_d = rom_idx_q;
    data_d    = data_q;
    valid_d   = valid_q;
    sof_d     = sof_q;
    eof_d     = eof_q;
    done_d    = 1'b0;
    pl_ready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_PATTERN;
          pat_cnt_d = '0;
          pl_cnt_d  = '0;
          rom_idx_d = '0;
        end
      end

      S_PATTERN: begin
        if (slot_free) begin
          data_d    = i_rom_data;
          valid_d   = 1'b1;
          sof_d     = (pat_cnt_q == 7'd0);
          eof_d     = 1'b0;
          pat_cnt_d = pat_cnt_q + 7'd1;
          if (pat_cnt_q == PAT_LAST) begin
            state_d = S_PAYLOAD;
          end else begin
            rom_idx_d = rom_idx_q + 6'd1;
          end
        end
      end

      S_PAYLOAD: begin
        pl_ready = slot_free;
        if (slot_free) begin
          if (i_pl_valid) begin
            data_d   = i_pl_data;
            valid_d  = 1'b1;
            sof_d    = 1'b0;
            eof_d    = (pl_cnt_q == PL_LAST);
            pl_cnt_d = pl_cnt_q + 1'b1;
            if (pl_cnt_q == PL_LAST) begin
              state_d = S_DRAIN;
            end
          end else begin
            // Source starved: emit a bubble rather than stall the link.
            valid_d = 1'b0;
          end
        end
      end

      S_DRAIN: begin
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_start_tx.sv
// Testbench for frame_start_tx: random backpressure and payload, scoreboard
// of expected words built from the frame rules, decoupled monitor.
module tb_frame_start_tx;

  localparam int PAT_LEN     = 64;
  localparam int PAYLOAD_LEN = 4;
  localparam int DATA_W      = 16;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_start;
  logic              o_busy;
  logic [5:0]        o_rom_index;
  logic [DATA_W-1:0] i_rom_data;
  logic [DATA_W-1:0] i_pl_data;
  logic              i_pl_valid;
  logic              o_pl_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_sof;
  logic              o_eof;
  logic              o_done;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eof;
  } word_t;

  word_t             exp_q[$];
  logic [DATA_W-1:0] pl_src[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_due = -1;
  int sof_cyc  = -1;
  int eof_cyc  = -1;
  bit rdy_random = 1'b0;
  bit starve_en  = 1'b0;

  // payload source state
  bit fire;
  int pops = 0;
  int starve_left = 0;
  int last_starve = -1;

  // monitor state
  word_t             e;
  bit                hold = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_sof;
  logic              prev_eof;

  int e1;

  frame_start_tx #(
    .PAT_LEN    (PAT_LEN),
    .PAYLOAD_LEN(PAYLOAD_LEN),
    .DATA_W     (DATA_W)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .o_rom_index(o_rom_index),
    .i_rom_data (i_rom_data),
    .i_pl_data  (i_pl_data),
    .i_pl_valid (i_pl_valid),
    .o_pl_ready (o_pl_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sof      (o_sof),
    .o_eof      (o_eof),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  // Frame-start pattern contents by index.
  function automatic logic [DATA_W-1:0] pat_word(input int k);
    if (k == 0)       return 16'hABCD;
    else if (k == 1)  return 16'hEF89;
    else if (k == 62) return 16'h4567;
    else if (k == 63) return 16'h3210;
    else if (k % 2 == 0) return 16'hBDE7;
    else              return 16'hF0A5;
  endfunction

  // External pattern ROM, combinational.
  always_comb i_rom_data = pat_word(int'(o_rom_index));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: one frame = PAT_LEN pattern words then PAYLOAD_LEN payload words.
  task automatic push_frame(input bit counting);
    logic [DATA_W-1:0] w;
    word_t x;
    for (int k = 0; k < PAT_LEN; k++) begin
      x.data = pat_word(k);
      x.sof  = (k == 0);
      x.eof  = 1'b0;
      exp_q.push_back(x);
    end
    for (int j = 0; j < PAYLOAD_LEN; j++) begin
      w = counting ? DATA_W'(j + 1) : DATA_W'($urandom);
      pl_src.push_back(w);
      x.data = w;
      x.sof  = 1'b0;
      x.eof  = (j == PAYLOAD_LEN - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic pulse_start();
    @(posedge i_clk); #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 3000) begin
      @(posedge i_clk);
      t++;
    end
    check("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_index(input int idx);
    int t = 0;
    while (!(o_busy && int'(o_rom_index) == idx) && t < 1000) begin
      @(negedge i_clk);
      t++;
    end
    check("reach_index", 32'(o_rom_index), 32'(idx));
  endtask

  // Downstream ready: always high or random per cycle.
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      i_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Payload source: presents queued words, optionally starves 5 cycles mid-payload.
  initial begin
    i_pl_valid = 1'b0;
    i_pl_data  = '0;
    forever begin
      @(negedge i_clk);
      fire = o_pl_ready && i_pl_valid;
      @(posedge i_clk); #1;
      if (i_rst) begin
        pl_src.delete();
      end else if (fire && pl_src.size() > 0) begin
        pl_src.delete(0);
        pops++;
      end
      if (starve_en && pops % PAYLOAD_LEN == 2 && last_starve != pops) begin
        starve_left = 5;
        last_starve = pops;
      end
      if (starve_left > 0) begin
        i_pl_valid = 1'b0;
        starve_left--;
      end else if (pl_src.size() > 0) begin
        i_pl_valid = 1'b1;
        i_pl_data  = pl_src[0];
      end else begin
        i_pl_valid = 1'b0;
      end
    end
  end

  // Monitor: compares accepted words against the scoreboard, checks hold and done.
  initial begin
    forever begin
      @(negedge i_clk);
      cyc++;
      if (i_rst) begin
        exp_q.delete();
        done_due = -1;
        hold     = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", 32'(o_valid), 32'd1);
          check("hold_word", 32'({o_data, o_sof, o_eof}), 32'({prev_data, prev_sof, prev_eof}));
        end
        if (o_done || cyc == done_due) begin
          check("done_pulse", 32'(o_done), 32'(cyc == done_due));
          if (o_done) done_cnt++;
        end
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %0h sof %0b eof %0b, none expected (cycle %0d)",
                     o_data, o_sof, o_eof, cyc);
          end else begin
            e = exp_q.pop_front();
            check("word", 32'({o_data, o_sof, o_eof}), 32'(e));
            if (e.sof) sof_cyc = cyc;
            if (e.eof) begin
              eof_cyc  = cyc;
              done_due = cyc + 1;
            end
          end
        end
        hold      = o_valid && !i_ready;
        prev_data = o_data;
        prev_sof  = o_sof;
        prev_eof  = o_eof;
      end
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Scenario sequencer.
  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    repeat (2) @(negedge i_clk);
    check("reset_state", 32'({o_data, o_valid, o_sof, o_eof, o_done, o_pl_ready, o_busy, o_rom_index}), 32'd0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // Basic frame at full rate, payload 1..4.
    push_frame(1'b1);
    pulse_start();
    @(negedge i_clk);
    check("start_busy", 32'(o_busy), 32'd1);
    check("start_no_valid", 32'(o_valid), 32'd0);
    @(negedge i_clk);
    check("first_word", 32'({o_valid, o_data, o_sof}), 32'({1'b1, 16'hABCD, 1'b1}));
    wait_done(1);
    @(negedge i_clk); #1;
    check("frame_len_full_rate", 32'(eof_cyc - sof_cyc), 32'(PAT_LEN + PAYLOAD_LEN - 1));
    check("idle_after_frame", 32'({o_busy, o_valid, o_pl_ready}), 32'd0);

    // Random backpressure.
    rdy_random = 1'b1;
    push_frame(1'b0);
    pulse_start();
    wait_done(2);
    rdy_random = 1'b0;
    check("drained_bp", 32'(exp_q.size()), 32'd0);

    // Payload starvation: 5 bubble cycles mid-payload.
    starve_en = 1'b1;
    push_frame(1'b0);
    pulse_start();
    wait_done(3);
    @(negedge i_clk); #1;
    starve_en = 1'b0;
    check("frame_len_starved", 32'(eof_cyc - sof_cyc), 32'(PAT_LEN + PAYLOAD_LEN - 1 + 5));

    // Start while busy is ignored.
    push_frame(1'b0);
    pulse_start();
    wait_index(10);
    pulse_start();
    wait_done(4);
    repeat (12) @(posedge i_clk);
    #1;
    check("single_frame_done", 32'(done_cnt), 32'd4);
    check("idle_after_ignored_start", 32'(o_busy), 32'd0);

    // Reset during pattern word 20.
    push_frame(1'b0);
    pulse_start();
    wait_index(20);
    #2 i_rst = 1'b1;
    #1;
    check("reset_mid_frame", 32'({o_data, o_valid, o_sof, o_eof, o_done, o_pl_ready, o_busy, o_rom_index}), 32'd0);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    check("no_done_on_reset", 32'(done_cnt), 32'd4);
    check("idle_after_reset", 32'(o_busy), 32'd0);
    push_frame(1'b0);
    pulse_start();
    wait_done(5);

    // Back-to-back frames with i_start held high.
    push_frame(1'b0);
    push_frame(1'b0);
    @(posedge i_clk); #1 i_start = 1'b1;
    wait_done(6);
    #1 i_start = 1'b0;
    e1 = eof_cyc;
    for (int t = 0; t < 20 && sof_cyc <= e1; t++) begin
      @(negedge i_clk); #1;
    end
    check("b2b_gap", 32'(sof_cyc - e1), 32'd3);
    wait_done(7);
    repeat (10) @(posedge i_clk);
    #1;
    check("final_done_count", 32'(done_cnt), 32'd7);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_start_tx.md
Name: frame_start_tx

Overview:
- Transmit-side frame sequencer that sits directly upstream of PATTERN_ROM.
- Drives the ROM's 6-bit index and consumes its combinational 16-bit pattern word.
- Each frame emits the 64-word frame-start pattern, then a fixed-length payload taken from an upstream valid/ready source.
- Output is a single registered valid/ready stream toward the link serializer, with start-of-frame and end-of-frame markers.

Parameters:
- PAT_LEN, 64, number of pattern words per frame. Range 1..64; index width is fixed at 6.
- PAYLOAD_LEN, 256, payload words per frame. Must be >= 1.
- DATA_W, 16, word width. Must match the ROM output width.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_start  in  1  frame request; sampled only in IDLE.
- o_busy  out  1  high in any state other than IDLE.
- o_rom_index  out  6  PATTERN_ROM address, equal to the pattern counter.
- i_rom_data  in  DATA_W  PATTERN_ROM data, combinational from o_rom_index.
- i_pl_data  in  DATA_W  payload word.
- i_pl_valid  in  1  payload word available.
- o_pl_ready  out  1  payload word is consumed this cycle.
- o_data  out  DATA_W  output word, registered.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  downstream accepts o_data.
- o_sof  out  1  qualifies o_data; marks the first pattern word.
- o_eof  out  1  qualifies o_data; marks the last payload word.
- o_done  out  1  one-cycle pulse after the last word of a frame is accepted.

Behaviour:
- Reset (async, i_rst=1): state=IDLE; counters=0; o_rom_index=0; o_data=0; o_valid, o_sof, o_eof, o_done, o_pl_ready, o_busy=0. Reset mid-frame aborts the frame with no completion pulse; on release the block waits in IDLE for a new i_start.
- Output slot free: slot_free = !o_valid || i_ready. o_data, o_sof and o_eof are held stable while o_valid && !i_ready.
- States:
  - IDLE: when i_start=1, go to PATTERN with pat_cnt=0 and pl_cnt=0. i_start in any other state is ignored and is not queued.
  - PATTERN: o_rom_index=pat_cnt. On slot_free, o_data<=i_rom_data, o_valid<=1, o_sof<=(pat_cnt==0), pat_cnt++. After the word at pat_cnt==PAT_LEN-1 is loaded, go to PAYLOAD.
  - PAYLOAD: o_pl_ready = slot_free. On o_pl_ready && i_pl_valid, o_data<=i_pl_data, o_valid<=1, o_eof<=(pl_cnt==PAYLOAD_LEN-1), pl_cnt++. On slot_free with !i_pl_valid, o_valid<=0 (bubble); no underflow error is raised. After the last payload word is loaded, go to DRAIN.
  - DRAIN: o_pl_ready=0. On o_valid && i_ready, set o_valid=0 and o_done=1 for one cycle, and go to IDLE.
- o_pl_ready is 0 outside PAYLOAD. o_rom_index holds its last value outside PATTERN.
- Latency and throughput:
  - i_start sampled at edge E0; the first word is valid after E1.
  - Sustained rate is 1 word/cycle with i_ready=1.
  - A frame at full rate is PAT_LEN+PAYLOAD_LEN data cycles plus 1 start cycle.
- Back-to-back frames: i_start is accepted in the same cycle o_done is high, because the state is already IDLE. The resulting inter-frame gap is 2 cycles without valid data.
- Counter widths: pat_cnt is 7 bits; pl_cnt is clog2(PAYLOAD_LEN+1) bits. Neither counter ever wraps inside a frame.

Test Plan:
- Basic frame (PAYLOAD_LEN=4, i_ready=1, i_pl_valid=1, payload 0x0001..0x0004, pulse i_start) -> 68 consecutive words:
  - ABCD with o_sof=1, then EF89, then BDE7/F0A5 alternating through index 61, then 4567, 3210.
  - Then 0001..0004, with o_eof=1 on 0004.
  - o_done pulses once, 1 cycle after 0004 is accepted.
- Backpressure (i_ready toggled pseudo-randomly) -> the identical 68-word sequence with no drops or duplicates. o_data stays stable whenever o_valid && !i_ready.
- Payload starvation (i_pl_valid low for 5 cycles mid-payload) -> o_valid bubbles. Word order is intact and o_eof still marks the 4th payload word.
- Start while busy (pulse i_start at pattern word 10) -> ignored. Exactly one frame is emitted and o_done pulses once.
- Reset at pattern word 20 -> all outputs 0 immediately, no o_done. A new i_start then produces a full frame beginning with ABCD and o_sof=1.
- Back-to-back (i_start held high) -> the second frame's ABCD appears 2 cycles after the first frame's 0004 is accepted.
